poly_eval_pipe: RTL and testbench



---
 rtl/poly_eval_pipe_pkg.sv | 49 ++++
 rtl/horner_stage.sv | 90 +++++++++
 rtl/poly_eval_pipe.sv | 171 +++++++++++++++++
 tb/tb_poly_eval_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_eval_pipe_pkg.sv
// ---------------------------------------------------------------------------
// poly_eval_pipe_pkg
//
// Shared constants for the pipelined Horner polynomial evaluator:
//   - default fixed-point formats (Q2.14 in, Q7.25 out) and degree
//   - helpers that derive the coefficient alignment shift and the
//     product slice base from the fraction points
//   - the exp(x) Taylor coefficients used as the reset coefficient set
//
// No ports; imported by poly_eval_pipe and horner_stage.
// ---------------------------------------------------------------------------
package poly_eval_pipe_pkg;

    // Default formats: x and coefficients are Q2.14, y is Q7.25.
    localparam int DEF_WIDTHIN  = 16;
    localparam int DEF_FRACIN   = 14;
    localparam int DEF_WIDTHOUT = 32;
    localparam int DEF_FRACOUT  = 25;
    localparam int DEF_DEGREE   = 5;

    // A coefficient moves into the output format by appending this many
    // zero fraction bits.
    function automatic int align_shift(input int fracout, input int fracin);
        return fracout - fracin;
    endfunction

    // acc (FRACOUT fraction bits) times x (FRACIN fraction bits) carries
    // FRACOUT+FRACIN fraction bits; dropping the low FRACIN bits brings the
    // product back to the accumulator format.
    function automatic int prod_base(input int fracin);
        return fracin;
    endfunction

    localparam int DEF_ALIGN_SHIFT = DEF_FRACOUT - DEF_FRACIN;
    localparam int DEF_PROD_BASE   = DEF_FRACIN;

    // exp(x) Taylor terms in Q2.14: 1, 1, 1/2, 1/6, 1/24, 1/120.
    localparam logic [DEF_WIDTHIN-1:0] EXP_C0 = 16'h4000;
    localparam logic [DEF_WIDTHIN-1:0] EXP_C1 = 16'h4000;
    localparam logic [DEF_WIDTHIN-1:0] EXP_C2 = 16'h2000;
    localparam logic [DEF_WIDTHIN-1:0] EXP_C3 = 16'h0AAA;
    localparam logic [DEF_WIDTHIN-1:0] EXP_C4 = 16'h02AA;
    localparam logic [DEF_WIDTHIN-1:0] EXP_C5 = 16'h0088;

    // Packed so that C[k] sits at bits [k*WIDTHIN +: WIDTHIN].
    localparam logic [(DEF_DEGREE+1)*DEF_WIDTHIN-1:0] DEF_COEF_INIT =
        {EXP_C5, EXP_C4, EXP_C3, EXP_C2, EXP_C1, EXP_C0};

endpackage : poly_eval_pipe_pkg

// File: rtl/horner_stage.sv
// ---------------------------------------------------------------------------
// horner_stage
//
// One Horner step: acc_out = (acc_in * x)[FRACIN +: WIDTHOUT] + align(coef),
// registered together with x and a valid bit. The stage only loads when
// en is high, so the whole pipeline stalls in lock-step.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   en          load enable (global pipeline advance)
//   i_valid     valid bit from previous stage
//   i_x         sample x from previous stage
//   i_acc       accumulator from previous stage
//   i_coef      coefficient added in this stage
//   o_valid     registered valid
//   o_x         registered x (forwarded to next stage)
//   o_acc       registered accumulator
// ---------------------------------------------------------------------------
module horner_stage
    import poly_eval_pipe_pkg::*;
#(
    parameter int WIDTHIN  = DEF_WIDTHIN,
    parameter int FRACIN   = DEF_FRACIN,
    parameter int WIDTHOUT = DEF_WIDTHOUT,
    parameter int FRACOUT  = DEF_FRACOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                i_valid,
    input  logic [WIDTHIN-1:0]  i_x,
    input  logic [WIDTHOUT-1:0] i_acc,
    input  logic [WIDTHIN-1:0]  i_coef,
    output logic                o_valid,
    output logic [WIDTHIN-1:0]  o_x,
    output logic [WIDTHOUT-1:0] o_acc
);

    localparam int ALIGN_SHIFT = align_shift(FRACOUT, FRACIN);
    localparam int PROD_BASE   = prod_base(FRACIN);
    localparam int PROD_W      = WIDTHOUT + WIDTHIN;

    logic [PROD_W-1:0]   prod;
    logic [WIDTHOUT-1:0] coef_aligned;
    logic                prod_unused;

    logic                valid_d, valid_q;
    logic [WIDTHIN-1:0]  x_d, x_q;
    logic [WIDTHOUT-1:0] acc_d, acc_q;

    // Full-width product so the slice sees every bit; the addition then
    // wraps modulo 2^WIDTHOUT without any overflow indication.
    always_comb begin
        prod         = PROD_W'(i_acc) * PROD_W'(i_x);
        coef_aligned = WIDTHOUT'(i_coef) << ALIGN_SHIFT;
    end

    // Bits outside the slice are intentionally discarded.
    assign prod_unused = ^prod;

    // Next-state: hold everything unless the pipeline advances.
    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        acc_d   = acc_q;
        if (en) begin
            valid_d = i_valid;
            x_d     = i_x;
            acc_d   = prod[PROD_BASE +: WIDTHOUT] + coef_aligned;
        end
    end

    // Stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_x     = x_q;
    assign o_acc   = acc_q;

endmodule : horner_stage

// File: rtl/poly_eval_pipe.sv
// ---------------------------------------------------------------------------
// poly_eval_pipe
//
// Fully pipelined Horner evaluator y = sum C[k] * x^k with DEGREE+1 stages,
// valid/ready backpressure and a runtime-writable coefficient bank.
//
// Stage 0 (here) loads x and align(C[DEGREE]); stages 1..DEGREE are
// horner_stage instances; stage DEGREE is the output register.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_valid / o_ready     input handshake (sample accepted on both high)
//   i_x                   sample x (unsigned, FRACIN fraction bits)
//   o_valid / i_ready     output handshake
//   o_y                   result (FRACOUT fraction bits, wraps)
//   i_coef_wr             coefficient write request, held until o_coef_ack
//   i_coef_idx            coefficient index k (k > DEGREE is dropped)
//   i_coef_data           new C[k]
//   o_coef_ack            one-cycle pulse after the write committed
// ---------------------------------------------------------------------------
module poly_eval_pipe
    import poly_eval_pipe_pkg::*;
#(
    parameter int WIDTHIN  = DEF_WIDTHIN,
    parameter int FRACIN   = DEF_FRACIN,
    parameter int WIDTHOUT = DEF_WIDTHOUT,
    parameter int FRACOUT  = DEF_FRACOUT,
    parameter int DEGREE   = DEF_DEGREE,
    parameter logic [(DEGREE+1)*WIDTHIN-1:0] COEF_INIT = DEF_COEF_INIT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WIDTHIN-1:0]           i_x,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTHOUT-1:0]          o_y,
    input  logic                         i_coef_wr,
    input  logic [$clog2(DEGREE+1)-1:0]  i_coef_idx,
    input  logic [WIDTHIN-1:0]           i_coef_data,
    output logic                         o_coef_ack
);

    localparam int ALIGN_SHIFT = align_shift(FRACOUT, FRACIN);

    // Pipeline control.
    logic adv;
    logic accept;
    logic any_valid;

    // Per-stage views of the pipeline; index 0 is the local stage 0.
    logic                valid_pipe [0:DEGREE];
    logic [WIDTHIN-1:0]  x_pipe     [0:DEGREE];
    logic [WIDTHOUT-1:0] acc_pipe   [0:DEGREE];
    logic                x_unused;

    // Stage 0 registers.
    logic                stage0_valid_d, stage0_valid_q;
    logic [WIDTHIN-1:0]  stage0_x_d,     stage0_x_q;
    logic [WIDTHOUT-1:0] stage0_acc_d,   stage0_acc_q;

    // Coefficient bank and write handshake.
    logic [WIDTHIN-1:0]  coef_d [0:DEGREE];
    logic [WIDTHIN-1:0]  coef_q [0:DEGREE];
    logic                coef_ack_d, coef_ack_q;
    logic                idx_ok;
    logic                commit;

    // A single advance signal stalls every stage together; bubbles stay
    // where they are, which keeps the control trivially simple.
    assign adv     = ~valid_pipe[DEGREE] | i_ready;
    assign o_ready = adv;
    assign accept  = i_valid & adv;

    // The pipeline counts as busy while any stage holds a sample.
    always_comb begin
        any_valid = 1'b0;
        for (int k = 0; k <= DEGREE; k++) begin
            any_valid = any_valid | valid_pipe[k];
        end
    end

    // Stage 0 next-state: capture x and the leading coefficient on advance.
    always_comb begin
        stage0_valid_d = stage0_valid_q;
        stage0_x_d     = stage0_x_q;
        stage0_acc_d   = stage0_acc_q;
        if (adv) begin
            stage0_valid_d = i_valid;
            stage0_x_d     = i_x;
            stage0_acc_d   = WIDTHOUT'(coef_q[DEGREE]) << ALIGN_SHIFT;
        end
    end

    // Stage 0 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage0_valid_q <= 1'b0;
            stage0_x_q     <= '0;
            stage0_acc_q   <= '0;
        end else begin
            stage0_valid_q <= stage0_valid_d;
            stage0_x_q     <= stage0_x_d;
            stage0_acc_q   <= stage0_acc_d;
        end
    end

    assign valid_pipe[0] = stage0_valid_q;
    assign x_pipe[0]     = stage0_x_q;
    assign acc_pipe[0]   = stage0_acc_q;

    // Horner stages 1..DEGREE; stage s adds C[DEGREE-s].
    for (genvar s = 1; s <= DEGREE; s++) begin : g_stage
        horner_stage #(
            .WIDTHIN  (WIDTHIN),
            .FRACIN   (FRACIN),
            .WIDTHOUT (WIDTHOUT),
            .FRACOUT  (FRACOUT)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (adv),
            .i_valid (valid_pipe[s-1]),
            .i_x     (x_pipe[s-1]),
            .i_acc   (acc_pipe[s-1]),
            .i_coef  (coef_q[DEGREE-s]),
            .o_valid (valid_pipe[s]),
            .o_x     (x_pipe[s]),
            .o_acc   (acc_pipe[s])
        );
    end

    // The last stage forwards x only for symmetry; nothing consumes it.
    assign x_unused = ^x_pipe[DEGREE];

    assign o_valid = valid_pipe[DEGREE];
    assign o_y     = acc_pipe[DEGREE];

    // Writes commit only with the pipeline empty and no sample entering,
    // so every in-flight sample sees one consistent coefficient set and no
    // per-stage coefficient copies are needed. An accepted sample wins over
    // a simultaneous write; the write then waits for the drain.
    always_comb begin
        idx_ok     = (int'(i_coef_idx) <= DEGREE);
        commit     = i_coef_wr & idx_ok & ~any_valid & ~accept;
        coef_ack_d = commit;
        coef_d     = coef_q;
        for (int k = 0; k <= DEGREE; k++) begin
            if (commit && (int'(i_coef_idx) == k)) begin
                coef_d[k] = i_coef_data;
            end
        end
    end

    // Coefficient bank registers; reset restores the initial set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= DEGREE; k++) begin
                coef_q[k] <= COEF_INIT[k*WIDTHIN +: WIDTHIN];
            end
            coef_ack_q <= 1'b0;
        end else begin
            coef_q     <= coef_d;
            coef_ack_q <= coef_ack_d;
        end
    end

    assign o_coef_ack = coef_ack_q;

endmodule : poly_eval_pipe

// File: tb/tb_poly_eval_pipe.sv
// ---------------------------------------------------------------------------
// tb_poly_eval_pipe
//
// Directed bench for poly_eval_pipe at default parameters. Expected results
// are pushed to a scoreboard queue when a sample is accepted and compared
// when the DUT hands the result downstream.
// ---------------------------------------------------------------------------
module tb_poly_eval_pipe;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_x;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_y;
    logic        i_coef_wr;
    logic [2:0]  i_coef_idx;
    logic [15:0] i_coef_data;
    logic        o_coef_ack;

    int          n_checks;
    int          n_errors;
    int          ready_mode;
    logic [31:0] exp_q[$];
    logic [15:0] tb_coef [0:5];
    bit          stall_prev;
    logic [31:0] held_y;

    poly_eval_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_x         (i_x),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_y         (o_y),
        .i_coef_wr   (i_coef_wr),
        .i_coef_idx  (i_coef_idx),
        .i_coef_data (i_coef_data),
        .o_coef_ack  (o_coef_ack)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare and count.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Coefficient set after reset: exp(x) Taylor terms in Q2.14.
    task automatic restoreCoefDefaults();
        tb_coef[0] = 16'h4000;
        tb_coef[1] = 16'h4000;
        tb_coef[2] = 16'h2000;
        tb_coef[3] = 16'h0AAA;
        tb_coef[4] = 16'h02AA;
        tb_coef[5] = 16'h0088;
    endtask

    // Horner reference in 64-bit integer arithmetic, wrapped to 32 bits.
    function automatic logic [31:0] model(input logic [15:0] x);
        longint unsigned acc;
        longint unsigned prod;
        acc = 64'(tb_coef[5]) << 11;
        for (int k = 4; k >= 0; k--) begin
            prod = acc * 64'(x);
            acc  = ((prod >> 14) + (64'(tb_coef[k]) << 11)) & 64'hFFFF_FFFF;
        end
        return acc[31:0];
    endfunction

    // Present one sample, wait until accepted, and record its expected y.
    task automatic applyStimulus(input logic [15:0] x, input logic [31:0] exp, output int waits);
        bit done;
        done    = 1'b0;
        waits   = 0;
        i_valid = 1'b1;
        i_x     = x;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (o_ready) done = 1'b1;
            @(posedge clk);
            if (done) exp_q.push_back(exp);
            else      waits++;
            #1;
        end
        if (!done) checkOutput("accept_timeout", 32'(done), 32'd1);
        i_valid = 1'b0;
    endtask

    // Wait until every expected result has come out.
    task automatic drainPipe(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || o_valid) && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput({tag, "_pending"}, exp_q.size(), 32'd0);
        checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
    endtask

    task automatic startWrite(input logic [2:0] idx, input logic [15:0] data);
        i_coef_wr   = 1'b1;
        i_coef_idx  = idx;
        i_coef_data = data;
    endtask

    // Hold the write until acked or the budget expires.
    task automatic waitAck(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk);
            #1;
            if (o_coef_ack) got = 1'b1;
        end
        i_coef_wr = 1'b0;
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = random.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) i_ready = 1'($urandom_range(0, 1));
            else                 i_ready = 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each transfer and checks that
    // a stalled output holds still.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("stall_hold_y", o_y, held_y);
                checkOutput("stall_hold_valid", 32'(o_valid), 32'd1);
            end
            if (o_valid && i_ready) begin
                n_checks++;
                assert (exp_q.size() != 0)
                else begin
                    n_errors++;
                    $error("[TB] FAIL unexpected_output: observed y %h with expected queue size %0d", o_y, exp_q.size());
                end
                if (exp_q.size() != 0) checkOutput("result", o_y, exp_q.pop_front());
            end
            stall_prev = o_valid && !i_ready;
            held_y     = o_y;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        int          w;
        int          waits_total;
        bit          got;
        logic [15:0] x;

        n_checks    = 0;
        n_errors    = 0;
        ready_mode  = 0;
        stall_prev  = 1'b0;
        held_y      = '0;
        reset       = 1'b1;
        i_valid     = 1'b0;
        i_x         = '0;
        i_coef_wr   = 1'b0;
        i_coef_idx  = '0;
        i_coef_data = '0;
        restoreCoefDefaults();

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_o_y", o_y, 32'd0);
        checkOutput("reset_o_coef_ack", 32'(o_coef_ack), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", 32'(o_ready), 32'd1);

        $display("[TB] default coefficients, directed x");
        applyStimulus(16'h0000, 32'h0200_0000, w);
        drainPipe("x0");
        applyStimulus(16'h4000, 32'h056E_E000, w);
        drainPipe("x1");

        $display("[TB] back-to-back stream, always ready");
        waits_total = 0;
        for (int i = 0; i < 20; i++) begin
            x = 16'($urandom_range(0, 65535));
            applyStimulus(x, model(x), w);
            waits_total += w;
        end
        checkOutput("stream_throughput_waits", waits_total, 32'd0);
        drainPipe("stream");

        $display("[TB] stream with random backpressure");
        ready_mode = 1;
        for (int i = 0; i < 20; i++) begin
            x = 16'($urandom_range(0, 65535));
            applyStimulus(x, model(x), w);
        end
        drainPipe("backpressure");
        ready_mode = 0;
        @(posedge clk);
        #1;

        $display("[TB] coefficient write while busy");
        startWrite(3'd0, 16'h8000);
        applyStimulus(16'h1234, model(16'h1234), w);
        checkOutput("sample_wins_over_write", w, 32'd0);
        applyStimulus(16'h4000, 32'h056E_E000, w);
        applyStimulus(16'h0000, 32'h0200_0000, w);
        checkOutput("no_ack_while_busy", 32'(o_coef_ack), 32'd0);
        waitAck(100, got);
        checkOutput("write_acked", 32'(got), 32'd1);
        checkOutput("ack_after_drain_pending", exp_q.size(), 32'd0);
        checkOutput("ack_after_drain_valid", 32'(o_valid), 32'd0);
        tb_coef[0] = 16'h8000;
        @(posedge clk);
        #1;
        checkOutput("ack_single_pulse", 32'(o_coef_ack), 32'd0);
        applyStimulus(16'h0000, 32'h0400_0000, w);
        drainPipe("new_c0");

        $display("[TB] out-of-range coefficient index");
        startWrite(3'd7, 16'h1234);
        waitAck(20, got);
        checkOutput("idx7_no_ack", 32'(got), 32'd0);
        applyStimulus(16'h4000, model(16'h4000), w);
        drainPipe("idx7_unchanged");

        $display("[TB] reset mid-stream");
        startWrite(3'd1, 16'h1111);
        for (int i = 0; i < 7; i++) begin
            x = 16'($urandom_range(0, 65535));
            applyStimulus(x, model(x), w);
        end
        checkOutput("valid_before_reset", 32'(o_valid), 32'd1);
        reset     = 1'b1;
        i_coef_wr = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midreset_o_valid", 32'(o_valid), 32'd0);
        checkOutput("midreset_o_y", o_y, 32'd0);
        checkOutput("midreset_o_coef_ack", 32'(o_coef_ack), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        restoreCoefDefaults();
        @(posedge clk);
        #1;
        applyStimulus(16'h0000, 32'h0200_0000, w);
        applyStimulus(16'h4000, 32'h056E_E000, w);
        drainPipe("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule : tb_poly_eval_pipe
